loop_filter_pi_gear: RTL and testbench
======================================

// Module: loop_filter_pi_gear
// PURPOSE
//  Synthesizable fixed-point PI loop filter for CFO/carrier tracking. Sits between the phase detector and the NCO.
//  Adds over the earlier single-gain filter: runtime shift-gains, two-gear operation (ACQ/TRK) driven by a lock FSM,
//  conditional-integration anti-windup, integrator hold and a saturation flag. Two-stage pipeline.
// PARAMETERS
//  ERR_WIDTH      24  phase_err_i width, Q1.(ERR_WIDTH-1)
//  PHASE_WIDTH    32  freq_word_o width, Q1.(PHASE_WIDTH-1); ACC_WIDTH >= PHASE_WIDTH >= ERR_WIDTH required
//  ACC_WIDTH      40  internal accumulator width, Q1.(ACC_WIDTH-1)
//  SHIFT_WIDTH    6   width of each gain-shift input
//  LOCK_CNT_WIDTH 12  lock/unlock run counter width
// PORTS
//  clk             in   1               clock
//  rst_n           in   1               async reset, active-low
//  err_valid_i     in   1               phase_err_i strobe
//  phase_err_i     in   ERR_WIDTH s     phase error
//  kp_acq_shift_i  in   SHIFT_WIDTH     ACQ prop gain = 2^-shift
//  ki_acq_shift_i  in   SHIFT_WIDTH     ACQ integral gain = 2^-shift
//  kp_trk_shift_i  in   SHIFT_WIDTH     TRK prop gain
//  ki_trk_shift_i  in   SHIFT_WIDTH     TRK integral gain
//  lock_thresh_i   in   ERR_WIDTH-1     |err| lock threshold (unsigned)
//  lock_count_i    in   LOCK_CNT_WIDTH  consecutive samples to lock/unlock (0 treated as 1)
//  hold_i          in   1               freeze integrator
//  freq_valid_o    out  1               freq_word_o strobe
//  freq_word_o     out  PHASE_WIDTH s   NCO frequency word
//  locked_o        out  1               1 = TRK gear
//  sat_o           out  1               last output saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): freq_word_o=0, freq_valid_o=0, locked_o=0, sat_o=0, integ=0, run counter=0, state=ACQ.
//  Latency: freq_valid_o pulses exactly 2 cycles after each err_valid_i; back-to-back valids fully supported.
//  Arithmetic:
//   - e = sext(phase_err_i) << (ACC_WIDTH-ERR_WIDTH).
//   - Shifts clamp to ACC_WIDTH-1; all shifts arithmetic, truncating.
//   - Stage 1: prop = e>>>kp; integ += e>>>ki, saturating to ACC range.
//   - Stage 2: sum = prop+integ in ACC_WIDTH+1 bits, saturated to ACC range; sat_o = (clipped);
//     freq_word_o = sum>>>(ACC_WIDTH-PHASE_WIDTH).
//  Gains: current state selects the ACQ or TRK shifts; a gear change applies from the sample after the transition sample.
//  Anti-windup: integ update skipped when sat_o=1 and sign(e) matches the clip direction.
//  hold_i=1: integ unchanged; prop path and FSM still run.
//  Lock FSM (advances on err_valid_i only); |err| of most-negative input = 2^(ERR_WIDTH-1)-1:
//   - ACQ: |err|<=thresh -> cnt++, else cnt=0; cnt reaches lock_count_i -> TRK, cnt=0.
//   - TRK: |err|>thresh -> cnt++, else cnt=0; reaches lock_count_i -> ACQ, cnt=0.
//   - Counter saturates at max.
//  locked_o updates in the same cycle as the freq_valid_o of the transition sample.
//  Gain/threshold inputs are sampled every valid; changing them mid-stream is legal and takes effect immediately.
//  rst_n mid-operation: in-flight samples are discarded; no freq_valid_o is emitted for them.
// CONFIGURATION
//  LF_PRELOAD_EN defined: adds ports preload_i (in, 1) and preload_val_i (in, PHASE_WIDTH s).
//   - preload_i=1: integ <= sext(preload_val_i)<<(ACC_WIDTH-PHASE_WIDTH); state and counter unchanged.
//   - Precedence: preload > hold_i > integration; preload with err_valid_i outputs prop + preloaded integ.
//  LF_PRELOAD_EN undefined: no such ports; integ changes only via integration or reset.
// TESTING (ERR=24, PHASE=32, ACC=40)
//  1. Reset, kp_acq=4, ki_acq=8, one err=0x400000 -> 2 cycles later freq_word_o=0x04400000, freq_valid_o=1, sat_o=0.
//  2. Same gains, three consecutive err=0x400000 -> outputs 0x04400000, 0x04800000, 0x04C00000 on consecutive cycles.
//  3. kp=ki=0, repeated err=0x7FFFFF -> freq_word_o=0x7FFFFFFF, sat_o=1; integ frozen.
//     err=-0x000100 then resumes integration.
//  4. thresh=0x000100, count=4:
//     - 4x err=0x000010 -> locked_o=1 with the 4th output.
//     - 3x err=0x010000 then 0x000010 -> stays 1.
//     - 4x 0x010000 -> locked_o=0.
//  5. hold_i=1, err=0x400000, kp=4, ki=8 from integ=0 -> freq_word_o=0x04000000 each sample; integ stays 0.
//  6. Stream valids, pull rst_n low mid-stream -> all outputs 0 immediately; no stale freq_valid_o after release.
//     LF_PRELOAD_EN: preload 0x01000000, err=0, kp=4 -> 0x01000000.

Source files
------------

// File: rtl/loop_filter_pi_gear.sv
// Two-gear (ACQ/TRK) fixed-point PI loop filter: shift gains, lock FSM, anti-windup, hold, 2-stage pipe.
// Define LF_PRELOAD_EN to add the integrator preload ports (preload_i, preload_val_i).
module loop_filter_pi_gear #(
    parameter int ERR_WIDTH      = 24,
    parameter int PHASE_WIDTH    = 32,
    parameter int ACC_WIDTH      = 40,
    parameter int SHIFT_WIDTH    = 6,
    parameter int LOCK_CNT_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          err_valid_i,
    input  logic signed [ERR_WIDTH-1:0]   phase_err_i,
    input  logic [SHIFT_WIDTH-1:0]        kp_acq_shift_i,
    input  logic [SHIFT_WIDTH-1:0]        ki_acq_shift_i,
    input  logic [SHIFT_WIDTH-1:0]        kp_trk_shift_i,
    input  logic [SHIFT_WIDTH-1:0]        ki_trk_shift_i,
    input  logic [ERR_WIDTH-2:0]          lock_thresh_i,
    input  logic [LOCK_CNT_WIDTH-1:0]     lock_count_i,
    input  logic                          hold_i,
    output logic                          freq_valid_o,
    output logic signed [PHASE_WIDTH-1:0] freq_word_o,
    output logic                          locked_o,
    output logic                          sat_o
`ifdef LF_PRELOAD_EN
    ,
    input  logic                          preload_i,
    input  logic signed [PHASE_WIDTH-1:0] preload_val_i
`endif
);

    localparam int unsigned SH_MAX = ACC_WIDTH - 1;
    localparam int unsigned ERR_SH = ACC_WIDTH - ERR_WIDTH;
    localparam int unsigned OUT_SH = ACC_WIDTH - PHASE_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ACQ = 1'b0, TRK = 1'b1} gear_t;

    function automatic int unsigned clamp_shift(input logic [SHIFT_WIDTH-1:0] s);
        if (32'(s) > SH_MAX)
            clamp_shift = SH_MAX;
        else
            clamp_shift = 32'(s);
    endfunction

    function automatic logic ovf_acc(input logic signed [ACC_WIDTH:0] x);
        ovf_acc = x[ACC_WIDTH] ^ x[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] x);
        if (ovf_acc(x))
            sat_acc = x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            sat_acc = x[ACC_WIDTH-1:0];
    endfunction

    gear_t                       gear;
    logic [LOCK_CNT_WIDTH-1:0]   run_cnt;
    logic signed [ACC_WIDTH-1:0] integ;
    logic                        sat_neg;

    logic signed [ACC_WIDTH-1:0] e_p0;
    logic signed [ACC_WIDTH-1:0] prop_p0;
    logic signed [ACC_WIDTH-1:0] inc_p0;
    logic signed [ACC_WIDTH-1:0] integ_nxt_p0;
    int unsigned                 kp_sh_p0;
    int unsigned                 ki_sh_p0;
    logic                        windup_p0;
    logic [ERR_WIDTH-2:0]        err_abs_p0;
    logic                        run_hit_p0;
    logic [LOCK_CNT_WIDTH-1:0]   cnt_nxt_p0;
    logic [LOCK_CNT_WIDTH-1:0]   cnt_tgt_p0;

    logic                        vld_p1;
    logic signed [ACC_WIDTH-1:0] prop_p1;
    logic signed [ACC_WIDTH:0]   sum_p1;
    logic signed [ACC_WIDTH-1:0] sum_sat_p1;

    // Stage p0 -> p1: gain select, proportional path, integrator update
    assign e_p0 = ACC_WIDTH'(phase_err_i) <<< ERR_SH;

    always_comb begin
        kp_sh_p0  = (gear == TRK) ? clamp_shift(kp_trk_shift_i) : clamp_shift(kp_acq_shift_i);
        ki_sh_p0  = (gear == TRK) ? clamp_shift(ki_trk_shift_i) : clamp_shift(ki_acq_shift_i);
        prop_p0   = e_p0 >>> kp_sh_p0;
        inc_p0    = e_p0 >>> ki_sh_p0;
        // pushing further into the rail the output already clipped against only winds the integrator up
        windup_p0 = sat_o && (e_p0[ACC_WIDTH-1] == sat_neg);
        integ_nxt_p0 = integ;
`ifdef LF_PRELOAD_EN
        if (preload_i)
            integ_nxt_p0 = ACC_WIDTH'(preload_val_i) <<< OUT_SH;
        else
`endif
        if (err_valid_i && !hold_i && !windup_p0)
            integ_nxt_p0 = sat_acc((ACC_WIDTH+1)'(integ) + (ACC_WIDTH+1)'(inc_p0));
    end

    always_comb begin
        if (phase_err_i[ERR_WIDTH-1]) begin
            if (phase_err_i[ERR_WIDTH-2:0] == '0)
                err_abs_p0 = '1;
            else
                err_abs_p0 = (ERR_WIDTH-1)'(-phase_err_i);
        end else begin
            err_abs_p0 = (ERR_WIDTH-1)'(phase_err_i);
        end
        run_hit_p0 = (gear == ACQ) ? (err_abs_p0 <= lock_thresh_i) : (err_abs_p0 > lock_thresh_i);
        if (!run_hit_p0)
            cnt_nxt_p0 = '0;
        else if (&run_cnt)
            cnt_nxt_p0 = run_cnt;
        else
            cnt_nxt_p0 = run_cnt + LOCK_CNT_WIDTH'(1);
        cnt_tgt_p0 = (lock_count_i == '0) ? LOCK_CNT_WIDTH'(1) : lock_count_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gear    <= ACQ;
            run_cnt <= '0;
        end else if (err_valid_i) begin
            if (cnt_nxt_p0 >= cnt_tgt_p0) begin
                gear    <= (gear == ACQ) ? TRK : ACQ;
                run_cnt <= '0;
            end else begin
                run_cnt <= cnt_nxt_p0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            integ  <= '0;
        end else begin
            vld_p1 <= err_valid_i;
            integ  <= integ_nxt_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (err_valid_i)
            prop_p1 <= prop_p0;
    end

    // Stage p1 -> p2: PI sum, output saturation, gear report
    always_comb begin
        sum_p1     = (ACC_WIDTH+1)'(prop_p1) + (ACC_WIDTH+1)'(integ);
        sum_sat_p1 = sat_acc(sum_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_valid_o <= 1'b0;
            freq_word_o  <= '0;
            locked_o     <= 1'b0;
            sat_o        <= 1'b0;
            sat_neg      <= 1'b0;
        end else begin
            freq_valid_o <= vld_p1;
            if (vld_p1) begin
                freq_word_o <= PHASE_WIDTH'(sum_sat_p1 >>> OUT_SH);
                locked_o    <= (gear == TRK);
                sat_o       <= ovf_acc(sum_p1);
                sat_neg     <= sum_p1[ACC_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_loop_filter_pi_gear.sv
// Directed-vector bench for loop_filter_pi_gear (ERR=24, PHASE=32, ACC=40).
module tb_loop_filter_pi_gear;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                err_valid;
    logic signed [23:0]  phase_err;
    logic [5:0]          kp_acq, ki_acq, kp_trk, ki_trk;
    logic [22:0]         thresh;
    logic [11:0]         lock_count;
    logic                hold;
    logic                freq_valid;
    logic signed [31:0]  freq_word;
    logic                locked;
    logic                sat;
`ifdef LF_PRELOAD_EN
    logic                preload;
    logic signed [31:0]  preload_val;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_word[$];
    logic        q_lock[$];
    logic        q_sat[$];

    always #5 clk = ~clk;

    loop_filter_pi_gear dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .err_valid_i    (err_valid),
        .phase_err_i    (phase_err),
        .kp_acq_shift_i (kp_acq),
        .ki_acq_shift_i (ki_acq),
        .kp_trk_shift_i (kp_trk),
        .ki_trk_shift_i (ki_trk),
        .lock_thresh_i  (thresh),
        .lock_count_i   (lock_count),
        .hold_i         (hold),
        .freq_valid_o   (freq_valid),
        .freq_word_o    (freq_word),
        .locked_o       (locked),
        .sat_o          (sat)
`ifdef LF_PRELOAD_EN
        ,
        .preload_i      (preload),
        .preload_val_i  (preload_val)
`endif
    );

    always @(negedge clk) begin
        if (rst_n && freq_valid) begin
            q_word.push_back(freq_word);
            q_lock.push_back(locked);
            q_sat.push_back(sat);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input logic [31:0] w,
                           input logic l, input logic s);
        check($sformatf("%s[%0d].word", tag, idx), q_word[idx], w);
        check($sformatf("%s[%0d].locked", tag, idx), q_lock[idx], l);
        check($sformatf("%s[%0d].sat", tag, idx), q_sat[idx], s);
    endtask

    task automatic send(input logic [23:0] e);
        @(negedge clk);
        err_valid = 1'b1;
        phase_err = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            err_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        err_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_word.delete();
        q_lock.delete();
        q_sat.delete();
    endtask

    logic [23:0] lock_seq[13];
    logic [31:0] lock_word[13];
    logic        lock_exp[13];

    initial begin
        rst_n = 1'b0; err_valid = 1'b0; phase_err = '0;
        kp_acq = 6'd4; ki_acq = 6'd8; kp_trk = 6'd4; ki_trk = 6'd8;
        thresh = '0; lock_count = 12'd4; hold = 1'b0;
`ifdef LF_PRELOAD_EN
        preload = 1'b0; preload_val = '0;
`endif

        // reset state
        repeat (2) @(negedge clk);
        check("rst.valid", freq_valid, 0);
        check("rst.word", freq_word, 0);
        check("rst.locked", locked, 0);
        check("rst.sat", sat, 0);
        rst_n = 1'b1;

        // single sample, exact 2-cycle latency
        send(24'h400000);
        @(negedge clk); err_valid = 1'b0;
        check("lat.cyc1_valid", freq_valid, 0);
        @(negedge clk);
        check("lat.cyc2_valid", freq_valid, 1);
        check("lat.word", freq_word, 32'h04400000);
        check("lat.sat", sat, 0);
        @(negedge clk);
        check("lat.pulse_end", freq_valid, 0);

        // back-to-back integration
        do_reset();
        repeat (3) send(24'h400000);
        idle(4);
        check("b2b.count", q_word.size(), 3);
        chk_out("b2b", 0, 32'h04400000, 0, 0);
        chk_out("b2b", 1, 32'h04800000, 0, 0);
        chk_out("b2b", 2, 32'h04C00000, 0, 0);

        // positive saturation, anti-windup freeze, recovery
        do_reset();
        kp_acq = 6'd0; ki_acq = 6'd0;
        send(24'h7FFFFF); idle(3);
        send(24'h7FFFFF); idle(3);
        send(24'hFFFF00); idle(3);
        check("sat.count", q_word.size(), 3);
        chk_out("sat", 0, 32'h7FFFFFFF, 0, 1);
        chk_out("sat", 1, 32'h7FFFFFFF, 0, 1);
        chk_out("sat", 2, 32'h7FFDFF00, 0, 0);

        // lock / unlock with gear-dependent proportional gain
        do_reset();
        kp_acq = 6'd0; ki_acq = 6'd63; kp_trk = 6'd2; ki_trk = 6'd63;
        thresh = 23'h000100; lock_count = 12'd4;
        lock_seq  = '{24'h10, 24'h10, 24'h10, 24'h10,
                      24'h10000, 24'h10000, 24'h10000, 24'h10,
                      24'h10000, 24'h10000, 24'h10000, 24'h10000, 24'h10};
        lock_word = '{32'h1000, 32'h1000, 32'h1000, 32'h1000,
                      32'h400000, 32'h400000, 32'h400000, 32'h400,
                      32'h400000, 32'h400000, 32'h400000, 32'h400000, 32'h1000};
        lock_exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) send(lock_seq[i]);
        idle(4);
        check("lock.count", q_word.size(), 13);
        for (int i = 0; i < 13; i++) chk_out("lock", i, lock_word[i], lock_exp[i], 0);

        // most-negative error magnitude, lock_count 0, negative clip
        do_reset();
        kp_acq = 6'd0; ki_acq = 6'd63; thresh = 23'h7FFFFE; lock_count = 12'd0;
        send(24'h800000); idle(3);
        send(24'h7FFFFE); idle(3);
        check("mneg.count", q_word.size(), 2);
        chk_out("mneg", 0, 32'h80000000, 0, 1);
        chk_out("mneg", 1, 32'h7FFFFDFF, 1, 0);

        // integrator hold
        do_reset();
        kp_acq = 6'd4; ki_acq = 6'd8; thresh = '0; lock_count = 12'd4;
        hold = 1'b1;
        repeat (3) send(24'h400000);
        idle(1);
        hold = 1'b0;
        send(24'h400000);
        idle(4);
        check("hold.count", q_word.size(), 4);
        chk_out("hold", 0, 32'h04000000, 0, 0);
        chk_out("hold", 1, 32'h04000000, 0, 0);
        chk_out("hold", 2, 32'h04000000, 0, 0);
        chk_out("hold", 3, 32'h04400000, 0, 0);

        // reset mid-stream
        do_reset();
        repeat (4) send(24'h400000);
        @(negedge clk);
        check("mrst.pre_valid", freq_valid, 1);
        rst_n = 1'b0;
        err_valid = 1'b0;
        #1;
        check("mrst.valid", freq_valid, 0);
        check("mrst.word", freq_word, 0);
        check("mrst.locked", locked, 0);
        check("mrst.sat", sat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_word.delete(); q_lock.delete(); q_sat.delete();
        idle(5);
        check("mrst.no_stale", q_word.size(), 0);

`ifdef LF_PRELOAD_EN
        do_reset();
        kp_acq = 6'd4;
        preload = 1'b1; preload_val = 32'h01000000;
        send(24'h000000);
        @(negedge clk);
        preload = 1'b0; err_valid = 1'b0;
        idle(3);
        check("pre.count", q_word.size(), 1);
        check("pre.word", q_word[0], 32'h01000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
